// File: rtl/ms_port_arbiter.sv
// ms_port_arbiter: round-robin arbiter that moves one value from either of two
// notify/sync requesters onto a single blocking master output port.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   reqN_in           requester N data
//   reqN_in_sync      requester N has valid data (held until reqN_notify)
//   reqN_notify       one-cycle pulse: requester N data captured
//   m_out             registered master data, stable until accepted
//   m_out_notify      master output valid
//   m_out_sync        consumer accepts m_out this cycle
//   xfer_count        completed transfers, wrapping
//   last_src          requester of the most recently completed transfer
module ms_port_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] req0_in,
  input  logic              req0_in_sync,
  output logic              req0_notify,
  input  logic [DATA_W-1:0] req1_in,
  input  logic              req1_in_sync,
  output logic              req1_notify,
  output logic [DATA_W-1:0] m_out,
  output logic              m_out_notify,
  input  logic              m_out_sync,
  output logic [CNT_W-1:0]  xfer_count,
  output logic              last_src
);

  typedef enum logic [0:0] {SectionIdle, SectionSend} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   m_out_q, m_out_d;
  logic                m_out_notify_q, m_out_notify_d;
  logic                req0_notify_q, req0_notify_d;
  logic                req1_notify_q, req1_notify_d;
  logic [CNT_W-1:0]    xfer_count_q, xfer_count_d;
  logic                last_src_q, last_src_d;
  logic                ptr_q, ptr_d;
  logic                cur_src_q, cur_src_d;
  logic                grant;

  // On a tie the requester that did not win last time is served; with a lone
  // request the active requester is served.
  always_comb begin
    if (req0_in_sync && req1_in_sync) begin
      grant = ~ptr_q;
    end else begin
      grant = req1_in_sync;
    end
  end

  always_comb begin
    state_d        = state_q;
    m_out_d        = m_out_q;
    m_out_notify_d = m_out_notify_q;
    req0_notify_d  = 1'b0;
    req1_notify_d  = 1'b0;
    xfer_count_d   = xfer_count_q;
    last_src_d     = last_src_q;
    ptr_d          = ptr_q;
    cur_src_d      = cur_src_q;

    unique case (state_q)
      SectionIdle: begin
        // m_out_sync is deliberately ignored here.
        if (req0_in_sync || req1_in_sync) begin
          m_out_d        = grant ? req1_in : req0_in;
          cur_src_d      = grant;
          m_out_notify_d = 1'b1;
          req0_notify_d  = ~grant;
          req1_notify_d  = grant;
          state_d        = SectionSend;
        end
      end
      SectionSend: begin
        // Requester syncs are ignored; no capture on the completion edge.
        if (m_out_sync) begin
          m_out_notify_d = 1'b0;
          xfer_count_d   = xfer_count_q + CNT_W'(1);
          last_src_d     = cur_src_q;
          ptr_d          = cur_src_q;
          state_d        = SectionIdle;
        end
      end
      default: state_d = SectionIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= SectionIdle;
      m_out_q        <= '0;
      m_out_notify_q <= 1'b0;
      req0_notify_q  <= 1'b0;
      req1_notify_q  <= 1'b0;
      xfer_count_q   <= '0;
      last_src_q     <= 1'b1;
      ptr_q          <= 1'b1;
      cur_src_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      m_out_q        <= m_out_d;
      m_out_notify_q <= m_out_notify_d;
      req0_notify_q  <= req0_notify_d;
      req1_notify_q  <= req1_notify_d;
      xfer_count_q   <= xfer_count_d;
      last_src_q     <= last_src_d;
      ptr_q          <= ptr_d;
      cur_src_q      <= cur_src_d;
    end
  end

  assign m_out        = m_out_q;
  assign m_out_notify = m_out_notify_q;
  assign req0_notify  = req0_notify_q;
  assign req1_notify  = req1_notify_q;
  assign xfer_count   = xfer_count_q;
  assign last_src     = last_src_q;

endmodule
